uart_rx_fifo: RTL and testbench

Clocked, parametrised receive FIFO sitting between the UART receiver and the host/bus read interface. It buffers received characters together with a per-character error tag, supports simultaneous push and pop, and exposes occupancy, threshold and sticky overflow/underflow status. It adds flush, flag-clear and BIST-freeze controls, all synchronous to a single clock.

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the host read port. Each entry holds
// a character plus its framing/parity error tag. Occupancy and sticky error flags are status outputs.
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int ADDR_BITS    = 4,
    parameter int AFULL_THRESH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 push_err,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_err,
    output logic                 rd_valid,
    input  logic                 flush,
    input  logic                 clr_flags,
    input  logic                 bist_mode,
    output logic [ADDR_BITS:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_LVL  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_LVL = (ADDR_BITS + 1)'(AFULL_THRESH);

    logic [DATA_BITS:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0] wptr;
    logic [ADDR_BITS-1:0] rptr;

    logic active;
    logic is_empty;
    logic is_full;
    logic do_push;
    logic do_pop;
    logic push_rej;
    logic pop_rej;

    // At full, a concurrent pop frees a slot on the same edge, so the push is accepted.
    always_comb begin
        active   = !flush && !bist_mode;
        is_empty = (count == '0);
        is_full  = (count == FULL_LVL);
        do_pop   = active && pop && !is_empty;
        do_push  = active && push && (!is_full || pop);
        push_rej = active && push && is_full && !pop;
        pop_rej  = active && pop && is_empty;
    end

    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count >= AFULL_LVL);

    // NOTE: storage has no reset; valid entries are tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wptr] <= {push_err, push_data};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            // Clear first so a same-cycle error event below takes precedence.
            if (clr_flags) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (push_rej) overflow  <= 1'b1;
            if (pop_rej)  underflow <= 1'b1;

            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (do_push) wptr <= wptr + 1'b1;
                if (do_pop) begin
                    {rd_err, rd_data} <= mem[rptr];
                    rd_valid          <= 1'b1;
                    rptr              <= rptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based model of the FIFO behaviour.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic       push_err = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       flush = 1'b0;
    logic       clr_flags = 1'b0;
    logic       bist_mode = 1'b0;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of {err, data} plus read register and sticky flags.
    logic [8:0] q[$];
    logic [7:0] m_rd_data;
    logic       m_rd_err;
    logic       m_rd_valid;
    logic       m_ov;
    logic       m_un;

    uart_rx_fifo #(.DATA_BITS(8), .ADDR_BITS(4), .AFULL_THRESH(AFULL)) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .push_err(push_err),
        .pop(pop), .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid),
        .flush(flush), .clr_flags(clr_flags), .bist_mode(bist_mode), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, take the edge, update the model, settle.
    task automatic step(input logic p, input logic [7:0] d, input logic e, input logic pp,
                        input logic fl, input logic clr, input logic bm, input logic r);
        logic [8:0] ent;
        int         sz;
        push = p; push_data = d; push_err = e; pop = pp;
        flush = fl; clr_flags = clr; bist_mode = bm; rst = r;
        @(posedge clk);
        m_rd_valid = 1'b0;
        if (r) begin
            q.delete();
            m_rd_data = '0; m_rd_err = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            if (clr) begin m_ov = 1'b0; m_un = 1'b0; end
            if (fl) begin
                q.delete();
            end else if (!bm) begin
                sz = q.size();
                if (pp && sz == 0) m_un = 1'b1;
                if (p && sz == DEPTH && !pp) m_ov = 1'b1;
                if (pp && sz > 0) begin
                    ent = q.pop_front();
                    {m_rd_err, m_rd_data} = ent;
                    m_rd_valid = 1'b1;
                end
                if (p && (sz < DEPTH || pp)) q.push_back({e, d});
            end
        end
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_flags = 1'b0; bist_mode = 1'b0; rst = 1'b0;
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 0, 0, 0, 1);
        n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", count); end
        n_checks++; if ({empty, full, almost_full} !== 3'b100) begin n_fail++; $display("FAIL reset_status: got e/f/af %b exp 100", {empty, full, almost_full}); end
        n_checks++; if ({rd_valid, rd_err, rd_data} !== 10'd0) begin n_fail++; $display("FAIL reset_rd: got v=%b e=%b d=%h exp 0", rd_valid, rd_err, rd_data); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b exp 00", {overflow, underflow}); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 0, 0, 0, 0);
            n_checks++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count: got %0d exp %0d", count, i + 1); end
            n_checks++; if (almost_full !== (i + 1 >= AFULL)) begin n_fail++; $display("FAIL fill_afull: got %b at count %0d", almost_full, i + 1); end
            n_checks++; if (full !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL fill_full: got %b at count %0d", full, i + 1); end
        end
        step(1, 8'hAA, 0, 0, 0, 0, 0, 0);
        n_checks++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL overflow: got ov=%b cnt=%0d exp 1/16", overflow, count); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 0, 1, 0, 0, 0, 0);
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain: got v=%b d=%h exp 1/%h", rd_valid, rd_data, 8'(i)); end
            n_checks++; if (count !== 5'(DEPTH - 1 - i)) begin n_fail++; $display("FAIL drain_count: got %0d exp %0d", count, DEPTH - 1 - i); end
        end
        idle();
        n_checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_end: got v=%b empty=%b exp 0/1", rd_valid, empty); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] first;
        step(0, 8'h00, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (i == 0) first = d;
            step(1, d, 0, 0, 0, 0, 0, 0);
        end
        step(1, 8'h55, 0, 1, 0, 0, 0, 0);
        n_checks++; if (rd_data !== first || rd_valid !== 1'b1) begin n_fail++; $display("FAIL full_pp_data: got %h v=%b exp %h", rd_data, rd_valid, first); end
        n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_status: got cnt=%0d ov=%b exp 16/0", count, overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 0, 1, 0, 0, 0, 0);
            n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL full_pp_drain: got %h exp %h", rd_data, m_rd_data); end
        end
        n_checks++; if (rd_data !== 8'h55 || empty !== 1'b1) begin n_fail++; $display("FAIL full_pp_last: got %h empty=%b exp 55/1", rd_data, empty); end
    endtask

    task automatic test_underflow_flags();
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL underflow: got un=%b v=%b exp 1/0", underflow, rd_valid); end
        step(0, 8'h00, 0, 0, 0, 1, 0, 0);
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_flags: got %b exp 00", {overflow, underflow}); end
        step(1, 8'h12, 0, 1, 0, 0, 0, 0);
        n_checks++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got cnt=%0d un=%b v=%b exp 1/1/0", count, underflow, rd_valid); end
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if (rd_data !== 8'h12 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL pp_empty_data: got %h v=%b exp 12/1", rd_data, rd_valid); end
        step(0, 8'h00, 0, 1, 0, 1, 0, 0);
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set: got un=%b exp 1", underflow); end
        step(0, 8'h00, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_err_tag();
        step(1, 8'h41, 1, 0, 0, 0, 0, 0);
        step(1, 8'h42, 0, 0, 0, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if ({rd_err, rd_data} !== 9'h141) begin n_fail++; $display("FAIL err_tag1: got e=%b d=%h exp 1/41", rd_err, rd_data); end
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if ({rd_err, rd_data} !== 9'h042) begin n_fail++; $display("FAIL err_tag0: got e=%b d=%h exp 0/42", rd_err, rd_data); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            logic       e;
            d = 8'($urandom);
            e = 1'($urandom);
            step(1, d, e, 0, 0, 0, 0, 0);
            step(0, 8'h00, 0, 1, 0, 0, 0, 0);
            n_checks++; if ({rd_err, rd_data} !== {e, d} || rd_valid !== 1'b1) begin n_fail++; $display("FAIL wrap[%0d]: got %b/%h exp %b/%h", i, rd_err, rd_data, e, d); end
        end
    endtask

    task automatic test_flush();
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0, 0, 0);
        step(1, 8'h99, 0, 0, 1, 0, 0, 0);
        n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d empty=%b exp 0/1", count, empty); end
        n_checks++; if ({overflow, underflow} !== 2'b01 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_flags: got %b v=%b exp 01/0", {overflow, underflow}, rd_valid); end
        step(1, 8'h33, 0, 0, 0, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if (rd_data !== 8'h33 || count !== 5'd0) begin n_fail++; $display("FAIL flush_nostore: got %h cnt=%0d exp 33/0", rd_data, count); end
    endtask

    task automatic test_bist();
        logic [7:0] held;
        for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0, 0, 0);
        held = rd_data;
        for (int i = 0; i < 10; i++) begin
            step(1, 8'($urandom), 0, 1, 0, 0, 1, 0);
            n_checks++; if (count !== 5'd3 || rd_valid !== 1'b0 || rd_data !== held) begin n_fail++; $display("FAIL bist_hold: got cnt=%0d v=%b d=%h exp 3/0/%h", count, rd_valid, rd_data, held); end
            n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL bist_flags: got %b exp 00", {overflow, underflow}); end
        end
        step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        n_checks++; if (rd_data !== 8'h60) begin n_fail++; $display("FAIL bist_ptr: got %h exp 60", rd_data); end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0, 0, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0, 0, 1);
        n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_count: got %0d empty=%b exp 0/1", count, empty); end
        n_checks++; if ({rd_valid, rd_data, overflow, underflow} !== 11'd0) begin n_fail++; $display("FAIL rst_mid_state: got v=%b d=%h ov=%b un=%b exp 0", rd_valid, rd_data, overflow, underflow); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            step(1'($urandom_range(0, 99) < bias), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 99) >= bias), 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 5), 0);
            n_checks++; if (count !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d exp %0d", i, count, q.size()); end
            n_checks++; if ({empty, full, almost_full} !== {q.size() == 0, q.size() == DEPTH, q.size() >= AFULL}) begin n_fail++; $display("FAIL rand_status[%0d]: got %b size %0d", i, {empty, full, almost_full}, q.size()); end
            n_checks++; if ({rd_valid, rd_err, rd_data} !== {m_rd_valid, m_rd_err, m_rd_data}) begin n_fail++; $display("FAIL rand_rd[%0d]: got %b/%b/%h exp %b/%b/%h", i, rd_valid, rd_err, rd_data, m_rd_valid, m_rd_err, m_rd_data); end
            n_checks++; if ({overflow, underflow} !== {m_ov, m_un}) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b exp %b", i, {overflow, underflow}, {m_ov, m_un}); end
        end
    endtask

    initial begin
        m_rd_data = '0; m_rd_err = 1'b0; m_rd_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        test_reset();
        test_fill_overflow();
        test_full_pushpop();
        test_underflow_flags();
        test_err_tag();
        test_wrap();
        test_flush();
        test_bist();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
